ev_session_table: RTL and testbench
===================================

# ev_session_table

Session-credential store directly downstream of `EV_CS_Authentication`. On each successful mutual authentication it records the EV pseudonym, the issued token `TK_i` and the session key `k_ki` in a fixed-depth table with a tick-based lifetime. It then answers charge-authorisation lookups from the charging-point controller with grant or deny. Expired sessions are invalidated and reported.

## Interface
- `DEPTH`, 4: number of session slots (power of two, 2..16).
- `T_VALID`, 60: session lifetime in `tick` pulses (1..65535, 16-bit counter).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `open_valid` / `open_ready`  in / out  1  handshake: store a session.
- `open_psid`, `open_tk`, `open_key`  in  64 each  pseudonym, token, session key.
- `open_done`  out  1  one-cycle completion pulse for an open.
- `open_ok`  out  1  qualifies `open_done`: 1 = stored, 0 = table full.
- `open_slot`  out  $clog2(DEPTH)  slot written; valid with `open_done`.
- `req_valid` / `req_ready`  in / out  1  handshake: authorisation lookup.
- `req_psid`, `req_tag`  in  64 each  pseudonym and proof tag.
- `resp_valid`  out  1  one-cycle lookup result pulse.
- `resp_grant`  out  1  qualifies `resp_valid`.
- `resp_slot`  out  $clog2(DEPTH)  matching slot; 0 when there is no match.
- `tick`  in  1  time-base strobe, one cycle wide.
- `expire_mask`  out  DEPTH  one-cycle pulse; bit i = slot i expired.
- `active_count`  out  $clog2(DEPTH)+1  number of valid slots.

## Operation
- **Slot contents:** `valid`, `psid`, `tk`, `key`, and a 16-bit `life` counter.
- **FSM states:** `IDLE`, `OPEN_SCAN`, `REQ_SCAN`, `RESP`.
- **Accepting work:** `open_ready` and `req_ready` are high only in `IDLE`, and both are 0 while `rst` is low.
  - If `open_valid` and `req_valid` are both high in `IDLE`, the open wins and `req_ready` is 0 that cycle.
- **Scanning:** both scans visit slot 0..DEPTH-1, one slot per cycle, always for the full DEPTH cycles, so latency is constant.
- **OPEN_SCAN:**
  - Records the first valid slot whose `psid == open_psid` (refresh) and the lowest-index invalid slot.
  - At the edge ending the last scan cycle, the target is written: the refresh slot if one was found, otherwise the free slot, otherwise nothing (`open_ok`=0).
  - The written slot gets `valid`=1, all fields loaded, and `life`=T_VALID.
- **REQ_SCAN:**
  - The first valid slot with `psid == req_psid` is the match.
  - Grant requires `req_tag == tk ^ key` and the slot not expiring on that same cycle.
  - If there is no match, `resp_grant`=0 and `resp_slot`=0.
- **RESP:** drives `open_done` or `resp_valid` (plus its qualifiers) for one cycle, then returns to `IDLE`.
- **Ageing:** on `tick`, every valid slot decrements `life`.
  - A slot at `life`==1 clears `valid` and sets its `expire_mask` bit the next cycle.
  - `life` never wraps below 0.
- **Tick and write on the same edge:** the write wins. The slot holds `life`=T_VALID with no decrement and no expire bit.
- **Scan-time state:** `psid`/`tk`/`key` are sampled from the registered slot at the cycle it is scanned.
  - A slot that expires after being scanned still yields the already-recorded result.
  - A grant is dropped only if the expiry happens on the scan cycle itself.
- **`active_count`:** the registered popcount of `valid`, updated the cycle after any write or expiry.

## Timing
- **Reset values:** every output is 0, all `valid` bits are 0, and the FSM is in `IDLE`. Reset is effective immediately (asynchronous); release is synchronous to `clk`.
- **Latency:** for a handshake on edge C, the scan occupies cycles C+1..C+DEPTH. The result pulse is high in cycle C+DEPTH+1, and ready is high again in cycle C+DEPTH+2.
- **Inputs:** `open_*` and `req_*` data are captured on the handshake edge and may change afterwards.
- **Reset mid-operation:** the table is cleared, no done or resp pulse is emitted, and the in-flight transaction is lost.
- **Arithmetic:** the tag comparison is a full 64-bit compare; `life` is unsigned 16-bit.

## Structure
- **Shared package:** the FSM state enum, `SESSION_LIFE_W`=16, and a slot struct typedef belong in a new `session_pkg`, alongside the existing `crypto_utils`. The tag function `tk ^ key` also goes there, so the authentication side can generate the same tag.
- **Sub-module:** one sub-module, `session_slot`. It holds the registers for one slot, with write-enable, tick decrement and expire-pulse logic, and is instantiated DEPTH times. The FSM and scan mux stay at top level.

## Test plan
All scenarios use DEPTH=4 and T_VALID=5.
- Open psid=0xA1, tk=0x10, key=0x01 → `open_done` at C+5 with `open_ok`=1, `open_slot`=0; `active_count`=1.
- Request psid=0xA1, tag=0x11 → `resp_grant`=1, `resp_slot`=0; a request with tag=0x12 → `resp_grant`=0.
- Open four distinct psids, then a fifth → `open_ok`=0 on the fifth; re-open psid of slot 2 → `open_ok`=1, `open_slot`=2, `life` restored to 5.
- Five ticks after an open → `expire_mask`=4'b0001 pulse, `active_count` drops by 1; a subsequent request for that psid → deny.
- `open_valid` and `req_valid` in the same cycle → only the open is accepted; `req_ready` rises again at C+6. A tick on the slot-write edge → that slot keeps `life`=5.
- Assert `rst` low during `REQ_SCAN` → no `resp_valid`, all slots invalid, `active_count`=0, both readys high after release.

Source files
------------

// File: rtl/session_pkg.sv
// Shared types for the EV session store: FSM states, slot record and the
// token/key proof tag that the authentication side also computes.
package session_pkg;

    localparam int unsigned SESSION_LIFE_W = 16;
    localparam int unsigned SESSION_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OPEN_SCAN = 2'd1,
        REQ_SCAN  = 2'd2,
        RESP      = 2'd3
    } sess_state_e;

    typedef struct packed {
        logic                      valid;
        logic [SESSION_DATA_W-1:0] psid;
        logic [SESSION_DATA_W-1:0] tk;
        logic [SESSION_DATA_W-1:0] key;
        logic [SESSION_LIFE_W-1:0] life;
    } session_slot_t;

    function automatic logic [SESSION_DATA_W-1:0] session_tag(
        input logic [SESSION_DATA_W-1:0] tk,
        input logic [SESSION_DATA_W-1:0] key
    );
        return tk ^ key;
    endfunction

endpackage

// File: rtl/session_slot.sv
// One session slot: credential registers, tick-driven lifetime and a
// one-cycle expiry pulse. A write on a tick edge takes priority.
module session_slot
    import session_pkg::*;
#(
    parameter int unsigned T_VALID = 60
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SESSION_DATA_W-1:0] wr_psid,
    input  logic [SESSION_DATA_W-1:0] wr_tk,
    input  logic [SESSION_DATA_W-1:0] wr_key,
    input  logic                      tick,
    output session_slot_t             slot,
    output logic                      expire,
    output logic                      expiring_c
);

    localparam logic [SESSION_LIFE_W-1:0] LIFE_INIT = SESSION_LIFE_W'(T_VALID);
    localparam logic [SESSION_LIFE_W-1:0] LIFE_ONE  = SESSION_LIFE_W'(1);

    // High on the cycle whose closing edge invalidates this slot.
    assign expiring_c = slot.valid && tick && (slot.life == LIFE_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot   <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (wr_en) begin
                slot.valid <= 1'b1;
                slot.psid  <= wr_psid;
                slot.tk    <= wr_tk;
                slot.key   <= wr_key;
                slot.life  <= LIFE_INIT;
            end else if (tick && slot.valid && (slot.life != '0)) begin
                slot.life <= slot.life - LIFE_ONE;
                if (expiring_c) begin
                    slot.valid <= 1'b0;
                    expire     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ev_session_table.sv
// Session-credential table: stores sessions after authentication, answers
// charge-authorisation lookups with a fixed-latency full scan, ages sessions.
module ev_session_table
    import session_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned T_VALID = 60
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       open_valid,
    output logic                       open_ready,
    input  logic [63:0]                open_psid,
    input  logic [63:0]                open_tk,
    input  logic [63:0]                open_key,
    output logic                       open_done,
    output logic                       open_ok,
    output logic [$clog2(DEPTH)-1:0]   open_slot,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [63:0]                req_psid,
    input  logic [63:0]                req_tag,
    output logic                       resp_valid,
    output logic                       resp_grant,
    output logic [$clog2(DEPTH)-1:0]   resp_slot,
    input  logic                       tick,
    output logic [DEPTH-1:0]           expire_mask,
    output logic [$clog2(DEPTH):0]     active_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned LAST  = DEPTH - 1;

    sess_state_e               state;
    logic                      rdy_q;
    logic [IDX_W-1:0]          scan_idx;
    logic [SESSION_DATA_W-1:0] cap_psid;
    logic [SESSION_DATA_W-1:0] cap_tk;
    logic [SESSION_DATA_W-1:0] cap_key;
    logic                      found_q;
    logic [IDX_W-1:0]          found_idx_q;
    logic                      grant_q;
    logic                      free_q;
    logic [IDX_W-1:0]          free_idx_q;

    session_slot_t             slots [DEPTH];
    logic [DEPTH-1:0]          expiring;
    logic [DEPTH-1:0]          wr_en_c;

    session_slot_t             cur;
    logic                      last_c;
    logic                      hit_c;
    logic                      found_c;
    logic [IDX_W-1:0]          found_idx_c;
    logic                      grant_c;
    logic                      free_c;
    logic [IDX_W-1:0]          free_idx_c;
    logic [CNT_W-1:0]          cnt_c;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        session_slot #(.T_VALID(T_VALID)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en_c[gi]),
            .wr_psid    (cap_psid),
            .wr_tk      (cap_tk),
            .wr_key     (cap_key),
            .tick       (tick),
            .slot       (slots[gi]),
            .expire     (expire_mask[gi]),
            .expiring_c (expiring[gi])
        );
    end

    assign open_ready = rdy_q;
    assign req_ready  = rdy_q && !open_valid;

    // Running scan results; the *_q copies hold what earlier slots produced.
    always_comb begin
        cur         = slots[scan_idx];
        last_c      = (scan_idx == IDX_W'(LAST));
        hit_c       = cur.valid && (cur.psid == cap_psid);
        found_c     = found_q || hit_c;
        found_idx_c = found_q ? found_idx_q : scan_idx;
        grant_c     = found_q ? grant_q
                              : (hit_c && (session_tag(cur.tk, cur.key) == cap_tk)
                                 && !expiring[scan_idx]);
        free_c      = free_q || !cur.valid;
        free_idx_c  = free_q ? free_idx_q : scan_idx;
        wr_en_c     = '0;
        if ((state == OPEN_SCAN) && last_c) begin
            if (found_c) begin
                wr_en_c[found_idx_c] = 1'b1;
            end else if (free_c) begin
                wr_en_c[free_idx_c] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_c = cnt_c + CNT_W'(slots[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rdy_q        <= 1'b0;
            scan_idx     <= '0;
            cap_psid     <= '0;
            cap_tk       <= '0;
            cap_key      <= '0;
            found_q      <= 1'b0;
            found_idx_q  <= '0;
            grant_q      <= 1'b0;
            free_q       <= 1'b0;
            free_idx_q   <= '0;
            open_done    <= 1'b0;
            open_ok      <= 1'b0;
            open_slot    <= '0;
            resp_valid   <= 1'b0;
            resp_grant   <= 1'b0;
            resp_slot    <= '0;
            active_count <= '0;
        end else begin
            open_done    <= 1'b0;
            open_ok      <= 1'b0;
            open_slot    <= '0;
            resp_valid   <= 1'b0;
            resp_grant   <= 1'b0;
            resp_slot    <= '0;
            active_count <= cnt_c;
            case (state)
                IDLE: begin
                    rdy_q       <= 1'b1;
                    scan_idx    <= '0;
                    found_q     <= 1'b0;
                    found_idx_q <= '0;
                    grant_q     <= 1'b0;
                    free_q      <= 1'b0;
                    free_idx_q  <= '0;
                    if (rdy_q && open_valid) begin
                        state    <= OPEN_SCAN;
                        rdy_q    <= 1'b0;
                        cap_psid <= open_psid;
                        cap_tk   <= open_tk;
                        cap_key  <= open_key;
                    end else if (rdy_q && req_valid) begin
                        state    <= REQ_SCAN;
                        rdy_q    <= 1'b0;
                        cap_psid <= req_psid;
                        cap_tk   <= req_tag;
                    end
                end
                OPEN_SCAN, REQ_SCAN: begin
                    found_q     <= found_c;
                    found_idx_q <= found_idx_c;
                    grant_q     <= grant_c;
                    free_q      <= free_c;
                    free_idx_q  <= free_idx_c;
                    scan_idx    <= scan_idx + IDX_W'(1);
                    if (last_c) begin
                        state <= RESP;
                        if (state == OPEN_SCAN) begin
                            open_done <= 1'b1;
                            open_ok   <= found_c || free_c;
                            open_slot <= found_c ? found_idx_c
                                                 : (free_c ? free_idx_c : '0);
                        end else begin
                            resp_valid <= 1'b1;
                            resp_grant <= grant_c;
                            resp_slot  <= found_c ? found_idx_c : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ev_session_table.sv
// Bench for ev_session_table: vector table, hand-written timing corners and
// random traffic checked against a slot-array reference model.
module tb_ev_session_table;

    localparam int DEPTH = 4;
    localparam int TV    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        open_valid = 1'b0, req_valid = 1'b0, tick = 1'b0;
    logic [63:0] open_psid = '0, open_tk = '0, open_key = '0;
    logic [63:0] req_psid = '0, req_tag = '0;
    logic        open_ready, open_done, open_ok, req_ready, resp_valid, resp_grant;
    logic [1:0]  open_slot, resp_slot;
    logic [3:0]  expire_mask;
    logic [2:0]  active_count;

    always #5 clk = ~clk;

    ev_session_table #(.DEPTH(DEPTH), .T_VALID(TV)) dut (
        .clk(clk), .rst(rst),
        .open_valid(open_valid), .open_ready(open_ready),
        .open_psid(open_psid), .open_tk(open_tk), .open_key(open_key),
        .open_done(open_done), .open_ok(open_ok), .open_slot(open_slot),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_psid(req_psid), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_grant(resp_grant), .resp_slot(resp_slot),
        .tick(tick), .expire_mask(expire_mask), .active_count(active_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: one entry per slot, lifetime counted in remaining ticks.
    bit          m_valid [DEPTH];
    logic [63:0] m_psid  [DEPTH];
    logic [63:0] m_tk    [DEPTH];
    logic [63:0] m_key   [DEPTH];
    int          m_life  [DEPTH];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_life[i] = 0;
        end
    endtask

    task automatic model_tick(output logic [3:0] mask);
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) begin
                m_life[i] = m_life[i] - 1;
                if (m_life[i] == 0) begin
                    m_valid[i] = 0;
                    mask[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_open(input logic [63:0] p, t, k, output bit ok, output int slot);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit < 0 && m_valid[i] && m_psid[i] == p) hit = i;
            if (fr < 0 && !m_valid[i]) fr = i;
        end
        slot = (hit >= 0) ? hit : fr;
        ok = (slot >= 0);
        if (ok) begin
            m_valid[slot] = 1; m_psid[slot] = p; m_tk[slot] = t;
            m_key[slot] = k; m_life[slot] = TV;
        end else begin
            slot = 0;
        end
    endtask

    task automatic model_req(input logic [63:0] p, tag, output bit g, output int slot);
        g = 0; slot = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_valid[i] && m_psid[i] == p) begin
                slot = i;
                g = (tag == (m_tk[i] ^ m_key[i]));
            end
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic wait_ready(input bit for_open);
        int n = 0;
        while (!(for_open ? open_ready : req_ready) && n < 50) begin
            @(negedge clk); n++;
        end
        check("ready_wait_bound", 64'(n < 50), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic do_open(input logic [63:0] p, t, k, input int tick_at,
                           output bit ok, output int slot);
        bit mok; int mslot; logic [3:0] msk; int cyc; bit seen;
        wait_ready(1);
        open_valid = 1; open_psid = p; open_tk = t; open_key = k;
        @(posedge clk); @(negedge clk);
        open_valid = 0; open_psid = ~p; open_tk = {$urandom, $urandom}; open_key = ~k;
        cyc = 1; seen = 0; ok = 0; slot = 0;
        while (cyc < 20 && !seen) begin
            tick = (cyc == tick_at);
            if (open_done) begin
                seen = 1; ok = open_ok; slot = int'(open_slot);
            end else begin
                @(negedge clk); cyc++;
            end
        end
        tick = 0;
        check("open_done_seen", 64'(seen), 64'd1);
        check("open_latency", 64'(cyc), 64'(DEPTH + 1));
        if (tick_at > 0) model_tick(msk);
        model_open(p, t, k, mok, mslot);
        check("open_ok_model", 64'(ok), 64'(mok));
        if (mok) check("open_slot_model", 64'(slot), 64'(mslot));
        @(negedge clk);
        check("open_active_count", 64'(active_count), 64'(model_count()));
    endtask

    task automatic do_req(input logic [63:0] p, tag, input int tick_at,
                          output bit g, output int slot);
        bit mg; int mslot; logic [3:0] msk; int cyc; bit seen;
        if (tick_at == 0) model_req(p, tag, mg, mslot);
        wait_ready(0);
        req_valid = 1; req_psid = p; req_tag = tag;
        @(posedge clk); @(negedge clk);
        req_valid = 0; req_psid = ~p; req_tag = ~tag;
        cyc = 1; seen = 0; g = 0; slot = 0;
        while (cyc < 20 && !seen) begin
            tick = (cyc == tick_at);
            if (resp_valid) begin
                seen = 1; g = resp_grant; slot = int'(resp_slot);
            end else begin
                @(negedge clk); cyc++;
            end
        end
        tick = 0;
        check("resp_seen", 64'(seen), 64'd1);
        check("resp_latency", 64'(cyc), 64'(DEPTH + 1));
        if (tick_at > 0) begin
            model_tick(msk);
        end else begin
            check("resp_grant_model", 64'(g), 64'(mg));
            check("resp_slot_model", 64'(slot), 64'(mslot));
        end
        @(negedge clk);
    endtask

    task automatic tick_pulse(output logic [3:0] seen_mask);
        logic [3:0] msk;
        tick = 1;
        @(negedge clk);
        tick = 0;
        model_tick(msk);
        seen_mask = expire_mask;
        check("expire_mask_model", 64'(expire_mask), 64'(msk));
        @(negedge clk);
        check("expire_pulse_width", 64'(expire_mask), 64'd0);
        check("tick_active_count", 64'(active_count), 64'(model_count()));
    endtask

    typedef struct {
        bit          is_open;
        logic [63:0] psid;
        logic [63:0] tk;
        logic [63:0] key_or_tag;
        bit          exp_ok;
        int          exp_slot;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok; bit g; int slot; int cyc; bit seen_done; bit seen_resp;
        logic [3:0] m;
        logic [63:0] p, t, k;

        vecs[0]  = '{1'b1, 64'hA1, 64'h10, 64'h01, 1'b1, 0};
        vecs[1]  = '{1'b0, 64'hA1, 64'h0,  64'h11, 1'b1, 0};
        vecs[2]  = '{1'b0, 64'hA1, 64'h0,  64'h12, 1'b0, 0};
        vecs[3]  = '{1'b0, 64'h77, 64'h0,  64'h00, 1'b0, 0};
        vecs[4]  = '{1'b1, 64'hB2, 64'h20, 64'h02, 1'b1, 1};
        vecs[5]  = '{1'b1, 64'hB3, 64'h30, 64'h03, 1'b1, 2};
        vecs[6]  = '{1'b1, 64'hB4, 64'h40, 64'h04, 1'b1, 3};
        vecs[7]  = '{1'b1, 64'hB5, 64'h50, 64'h05, 1'b0, 0};
        vecs[8]  = '{1'b1, 64'hB3, 64'h33, 64'h0C, 1'b1, 2};
        vecs[9]  = '{1'b0, 64'hB3, 64'h0,  64'h3F, 1'b1, 2};
        vecs[10] = '{1'b0, 64'hB3, 64'h0,  64'h33, 1'b0, 2};
        vecs[11] = '{1'b0, 64'hB4, 64'h0,  64'h44, 1'b1, 3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_open_ready", 64'(open_ready), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_open_done", 64'(open_done), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_expire_mask", 64'(expire_mask), 64'd0);
        check("rst_active_count", 64'(active_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        check("release_open_ready", 64'(open_ready), 64'd1);
        check("release_req_ready", 64'(req_ready), 64'd1);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_open) begin
                do_open(vecs[i].psid, vecs[i].tk, vecs[i].key_or_tag, 0, ok, slot);
                check($sformatf("vec%0d_open_ok", i), 64'(ok), 64'(vecs[i].exp_ok));
                if (vecs[i].exp_ok)
                    check($sformatf("vec%0d_open_slot", i), 64'(slot), 64'(vecs[i].exp_slot));
            end else begin
                do_req(vecs[i].psid, vecs[i].key_or_tag, 0, g, slot);
                check($sformatf("vec%0d_grant", i), 64'(g), 64'(vecs[i].exp_ok));
                check($sformatf("vec%0d_resp_slot", i), 64'(slot), 64'(vecs[i].exp_slot));
            end
        end
        check("table_full_count", 64'(active_count), 64'd4);

        // Refresh restores lifetime; expiry after five ticks
        do_reset();
        do_open(64'hD1, 64'h10, 64'h01, 0, ok, slot);
        tick_pulse(m); tick_pulse(m);
        do_open(64'hD1, 64'h10, 64'h01, 0, ok, slot);
        check("refresh_slot", 64'(slot), 64'd0);
        repeat (4) tick_pulse(m);
        check("refresh_no_early_expire", 64'(m), 64'd0);
        check("refresh_active", 64'(active_count), 64'd1);
        tick_pulse(m);
        check("expire_0001", 64'(m), 64'h1);
        check("expire_active_drop", 64'(active_count), 64'd0);
        do_req(64'hD1, 64'h11, 0, g, slot);
        check("expired_deny", 64'(g), 64'd0);

        // Tick on the write edge: written slot keeps full lifetime
        do_reset();
        do_open(64'hE1, 64'h1, 64'h2, DEPTH, ok, slot);
        repeat (4) tick_pulse(m);
        check("wr_tick_no_early_expire", 64'(m), 64'd0);
        tick_pulse(m);
        check("wr_tick_expire_fifth", 64'(m), 64'h1);

        // Open and request in the same cycle
        do_reset();
        wait_ready(1);
        open_valid = 1; open_psid = 64'hC1; open_tk = 64'h5; open_key = 64'h6;
        req_valid = 1; req_psid = 64'hC1; req_tag = 64'h3;
        #1;
        check("both_req_ready_low", 64'(req_ready), 64'd0);
        check("both_open_ready_high", 64'(open_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        open_valid = 0; req_valid = 0;
        cyc = 1; seen_done = 0; seen_resp = 0;
        while (cyc < 20 && !req_ready) begin
            if (open_done) seen_done = 1;
            if (resp_valid) seen_resp = 1;
            @(negedge clk); cyc++;
        end
        check("both_req_ready_rise", 64'(cyc), 64'd6);
        check("both_open_done", 64'(seen_done), 64'd1);
        check("both_no_resp", 64'(seen_resp), 64'd0);
        model_open(64'hC1, 64'h5, 64'h6, ok, slot);
        check("both_active", 64'(active_count), 64'(model_count()));

        // Expiry after the matching slot was scanned keeps the grant
        do_reset();
        do_open(64'hF0, 64'h1, 64'h2, 0, ok, slot);
        do_open(64'hF1, 64'h5A, 64'hA5, 0, ok, slot);
        repeat (4) tick_pulse(m);
        do_req(64'hF1, 64'hFF, 3, g, slot);
        check("late_expire_grant", 64'(g), 64'd1);
        check("late_expire_slot", 64'(slot), 64'd1);
        check("late_expire_active", 64'(active_count), 64'd0);

        // Expiry on the matching slot's own scan cycle drops the grant
        do_reset();
        do_open(64'hF0, 64'h1, 64'h2, 0, ok, slot);
        do_open(64'hF1, 64'h5A, 64'hA5, 0, ok, slot);
        repeat (4) tick_pulse(m);
        do_req(64'hF1, 64'hFF, 2, g, slot);
        check("same_cycle_expire_grant", 64'(g), 64'd0);
        check("same_cycle_expire_slot", 64'(slot), 64'd1);

        // Reset during a lookup scan
        do_reset();
        do_open(64'h91, 64'h1, 64'h1, 0, ok, slot);
        do_open(64'h92, 64'h2, 64'h2, 0, ok, slot);
        wait_ready(0);
        req_valid = 1; req_psid = 64'h92; req_tag = 64'h0;
        @(posedge clk); @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_active", 64'(active_count), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        seen_resp = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1;
        end
        check("mid_rst_no_resp", 64'(seen_resp), 64'd0);
        check("mid_rst_open_ready", 64'(open_ready), 64'd1);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_active_after", 64'(active_count), 64'd0);
        do_req(64'h92, 64'h0, 0, g, slot);
        check("mid_rst_lookup_deny", 64'(g), 64'd0);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(0, 3));
            p = 64'h100 + 64'($urandom_range(0, 5));
            if (r <= 1) begin
                t = {$urandom, $urandom}; k = {$urandom, $urandom};
                do_open(p, t, k, 0, ok, slot);
            end else if (r == 2) begin
                t = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = DEPTH - 1; i >= 0; i--)
                        if (m_valid[i] && m_psid[i] == p) t = m_tk[i] ^ m_key[i];
                end
                do_req(p, t, 0, g, slot);
            end else begin
                tick_pulse(m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
